// File: rtl/uart_rx_deser.sv
// UART receiver: synchronises rx_sig, samples each bit at mid-bit, and presents
// each received byte through a one-entry valid/ready holding register.
module uart_rx_deser #(
    parameter int DATA_BITS = 8,
    parameter int BAUD      = 115200,
    parameter int CLK_FREQ  = 100_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_sig,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   sync1_q, rxs_q, rxs_prev_q;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q;
    logic                   complete_s;
    logic                   ferr_s;
    logic                   fall_s;

    assign fall_s = ~rxs_q & rxs_prev_q;

    // Two-flop synchroniser plus previous-value flop for edge detection.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= rx_sig;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Frame FSM next-state: bit timing counter, bit index and shift register.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        shift_d    = shift_q;
        complete_s = 1'b0;
        ferr_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs_q;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_STOP: begin
                // Leaving at mid-stop keeps a back-to-back start edge visible.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        complete_s = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rxs_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Holding register: accept on completion if empty or draining this cycle.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        frame_err_d = ferr_s;
        if (complete_s) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser at 16 clocks per bit: frames are pushed
// when sent and compared when valid rises; flag pulses are counted by a monitor.
module tb_uart_rx_deser;

    logic       clock;
    logic       reset;
    logic       rx_sig;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks_cnt   = 0;
    int failures_cnt = 0;
    int cyc          = 0;
    int rise_cyc     = 0;
    int prev_rise    = 0;
    int last_start   = 0;
    int vw           = 0;
    int last_vw      = 0;
    int ferr_cnt     = 0;
    int ovr_cnt      = 0;
    logic valid_prev = 1'b0;
    logic ferr_prev  = 1'b0;
    logic ovr_prev   = 1'b0;
    logic [7:0] sb_q[$];

    uart_rx_deser #(.DATA_BITS(8), .BAUD(1), .CLK_FREQ(16)) dut (
        .clock(clock), .reset(reset), .rx_sig(rx_sig), .data(data),
        .valid(valid), .ready(ready), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drives one 10-bit frame; caller is positioned just after a clock edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic expect_out);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        if (expect_out) sb_q.push_back(b);
        last_start = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            rx_sig = bits[i];
            tick(16);
        end
        rx_sig = 1'b1;
    endtask

    // Output monitor: scoreboard compare on valid rise, pulse accounting.
    always @(negedge clock) begin
        if (valid && !valid_prev) begin
            prev_rise = rise_cyc;
            rise_cyc  = cyc;
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("rx_data", {24'd0, data}, {24'd0, sb_q.pop_front()});
            end
        end
        if (valid) begin
            vw++;
        end else if (valid_prev) begin
            last_vw = vw;
            vw = 0;
        end
        if (frame_err) begin
            ferr_cnt++;
            check("frame_err_width", {31'd0, ferr_prev}, 32'd0);
        end
        if (overrun) begin
            ovr_cnt++;
            check("overrun_width", {31'd0, ovr_prev}, 32'd0);
        end
        if (frame_err || overrun) check("flags_exclusive", {31'd0, frame_err & overrun}, 32'd0);
        valid_prev = valid;
        ferr_prev  = frame_err;
        ovr_prev   = overrun;
    end

    initial begin
        int f0, o0;
        logic [7:0] b77;
        reset  = 1'b0;
        rx_sig = 1'b1;
        ready  = 1'b1;
        tick(3);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        tick(5);

        // Single frame, latency and one-cycle valid.
        f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        tick(4);
        check("s1_latency", rise_cyc - last_start, 32'd154);
        check("s1_valid_width", last_vw, 32'd1);
        check("s1_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);

        // Back-to-back frames.
        send_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'h81, 1'b1, 1'b1);
        tick(4);
        check("s2_spacing", rise_cyc - prev_rise, 32'd160);
        check("s2_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);

        // Start glitch.
        rx_sig = 1'b0;
        tick(4);
        rx_sig = 1'b1;
        check("s3_busy_during", {31'd0, busy}, 32'd1);
        tick(20);
        check("s3_busy_after", {31'd0, busy}, 32'd0);
        check("s3_valid", {31'd0, valid}, 32'd0);
        check("s3_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);

        // Framing error, held break, then recovery.
        send_frame(8'h55, 1'b0, 1'b0);
        rx_sig = 1'b0;
        tick(40);
        check("s4_frame_err", ferr_cnt - f0, 32'd1);
        check("s4_busy_break", {31'd0, busy}, 32'd1);
        check("s4_valid", {31'd0, valid}, 32'd0);
        rx_sig = 1'b1;
        tick(4);
        check("s4_busy_release", {31'd0, busy}, 32'd0);
        send_frame(8'h12, 1'b1, 1'b1);
        tick(4);
        check("s4_sb_drained", sb_q.size(), 32'd0);

        // Overrun with ready low.
        f0 = ferr_cnt; o0 = ovr_cnt;
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0);
        tick(4);
        check("s5_overrun", ovr_cnt - o0, 32'd1);
        check("s5_valid_held", {31'd0, valid}, 32'd1);
        check("s5_data_held", {24'd0, data}, 32'h11);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("s5_valid_drained", {31'd0, valid}, 32'd0);
        check("s5_data_kept", {24'd0, data}, 32'h11);
        ready = 1'b1;
        tick(2);

        // Reset in the middle of data bit 4.
        b77 = 8'h77;
        rx_sig = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            rx_sig = b77[i];
            tick(16);
        end
        rx_sig = b77[4];
        tick(8);
        reset  = 1'b0;
        rx_sig = 1'b1;
        tick(3);
        check("s6_rst_data", {24'd0, data}, 32'd0);
        check("s6_rst_valid", {31'd0, valid}, 32'd0);
        check("s6_rst_busy", {31'd0, busy}, 32'd0);
        check("s6_rst_flags", {30'd0, frame_err, overrun}, 32'd0);
        reset = 1'b1;
        tick(20);
        check("s6_no_output", {31'd0, valid}, 32'd0);
        send_frame(8'h9E, 1'b1, 1'b1);
        tick(4);
        check("s6_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 32'd1);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
